wb_burst_master: RTL

Pipelined Wishbone initiator that performs single-command bursts of word reads or writes against a Wishbone responder, such as the on-chip sample/frame RAM.
- Write bursts take data from a valid/ready stream.
- Read bursts deliver returned data on a valid-only stream.
- Sits between the capture/beamforming datapath (or CPU command logic) and the memory-side Wishbone bus.

---
 rtl/wb_burst_master.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// Pipelined Wishbone initiator for single-command word bursts.
// Writes drain a valid/ready stream; reads return on a valid-only stream.
module wb_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 12,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_done,
  output logic              o_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DATA_W-1:0] i_wb_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  localparam int OUT_W = 5;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t r_state, w_state_n;

  logic              r_we,     w_we_n;
  logic [ADDR_W-1:0] r_addr,   w_addr_n;
  logic [DATA_W-1:0] r_data,   w_data_n;
  logic [LEN_W-1:0]  r_len,    w_len_n;
  logic [LEN_W-1:0]  r_issued, w_issued_n;
  logic [LEN_W-1:0]  r_acked,  w_acked_n;
  logic [OUT_W-1:0]  r_out,    w_out_n;
  logic [WD_W-1:0]   r_wdog,   w_wdog_n;
  logic              r_stb,    w_stb_n;
  logic              r_done,   w_done_n;
  logic              r_err,    w_err_n;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_busy;
  logic              w_accept;
  logic              w_ack;
  logic              w_out_ok;
  logic              w_load;
  logic              w_timeout;
  logic              w_last_ack;
  logic [LEN_W-1:0]  w_iss_acc;
  logic [LEN_W-1:0]  w_ack_cnt;
  logic [OUT_W-1:0]  w_out_acc;

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = r_stb & ~i_wb_stall;
  assign w_ack    = w_busy & i_wb_ack;

  assign w_iss_acc = r_issued + LEN_W'(w_accept);
  assign w_ack_cnt = r_acked + LEN_W'(w_ack);
  assign w_out_acc = r_out + OUT_W'(w_accept) - OUT_W'(w_ack);
  assign w_out_ok  = (w_out_acc < OUT_W'(MAX_OUT));

  // A new beat may be staged once the bus slot frees up this cycle.
  assign w_load = (r_state == S_ISSUE)
                & (~r_stb | ~i_wb_stall)
                & (w_iss_acc < r_len)
                & w_out_ok
                & (~r_we | i_wr_valid);

  assign w_last_ack = w_ack & (w_ack_cnt == r_len);

  assign w_timeout = w_busy
                   & (r_out != '0)
                   & ~w_ack
                   & (r_wdog == WD_W'(TIMEOUT - 1));

  always_comb begin
    w_state_n  = r_state;
    w_we_n     = r_we;
    w_addr_n   = r_addr;
    w_data_n   = r_data;
    w_len_n    = r_len;
    w_issued_n = r_issued;
    w_acked_n  = r_acked;
    w_out_n    = r_out;
    w_wdog_n   = r_wdog;
    w_stb_n    = r_stb;
    w_done_n   = 1'b0;
    w_err_n    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_we_n     = i_cmd_we;
          w_addr_n   = i_cmd_addr;
          w_len_n    = i_cmd_len;
          w_issued_n = '0;
          w_acked_n  = '0;
          w_out_n    = '0;
          w_wdog_n   = '0;
          w_stb_n    = 1'b0;
          if (i_cmd_len == '0) begin
            w_done_n = 1'b1;
          end else begin
            w_state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE, S_DRAIN: begin
        w_issued_n = w_iss_acc;
        w_acked_n  = w_ack_cnt;
        w_out_n    = w_out_acc;
        if (w_ack || (r_out == '0)) begin
          w_wdog_n = '0;
        end else begin
          w_wdog_n = r_wdog + WD_W'(1);
        end
        if (w_accept) begin
          w_addr_n = r_addr + ADDR_W'(1);
        end
        if (w_load) begin
          w_stb_n = 1'b1;
          if (r_we) begin
            w_data_n = i_wr_data;
          end
        end else if (w_accept) begin
          w_stb_n = 1'b0;
        end
        if ((r_state == S_ISSUE) && w_accept
            && (w_iss_acc == r_len)) begin
          w_state_n = S_DRAIN;
        end
        // Final ack may land with its own accept.
        if (w_last_ack) begin
          w_state_n = S_IDLE;
          w_stb_n   = 1'b0;
          w_wdog_n  = '0;
          w_done_n  = 1'b1;
        end else if (w_timeout) begin
          w_state_n = S_IDLE;
          w_stb_n   = 1'b0;
          w_wdog_n  = '0;
          w_done_n  = 1'b1;
          w_err_n   = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_stb_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_acked  <= '0;
      r_out    <= '0;
      r_wdog   <= '0;
      r_stb    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_we     <= w_we_n;
      r_addr   <= w_addr_n;
      r_data   <= w_data_n;
      r_len    <= w_len_n;
      r_issued <= w_issued_n;
      r_acked  <= w_acked_n;
      r_out    <= w_out_n;
      r_wdog   <= w_wdog_n;
      r_stb    <= w_stb_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_ack & ~r_we;
      if (w_ack && !r_we) begin
        r_rd_data <= i_wb_data;
      end
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_wr_ready  = r_we & w_load;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_wb_cyc    = w_busy;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_addr   = r_addr;
  assign o_wb_data   = r_data;

endmodule
